round_controller: RTL

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/round_controller_pkg.sv | 28 ++
 rtl/round_controller_seg7_decoder.sv | 27 ++
 rtl/round_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/round_controller_pkg.sv
// Shared encodings for the round controller: phases, hit codes, winner codes
// and the seven-segment blank digit.
package round_controller_pkg;

  typedef enum logic [1:0] {
    PH_FIGHT = 2'b00,
    PH_KO    = 2'b01,
    PH_OVER  = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BASIC = 2'b01;

  localparam logic [3:0] DIGIT_BLANK = 4'd15;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  // Packs {tens, ones} for a 0..99 health value; tens is blanked below 10.
  function automatic logic [7:0] health_digits(input logic [6:0] value);
    return {(value < 7'd10) ? DIGIT_BLANK : 4'(value / 7'd10), 4'(value % 7'd10)};
  endfunction

endpackage

// File: rtl/round_controller_seg7_decoder.sv
// Decimal digit to active-low seven-segment pattern (bit0 = segment a).
// Any code above 9, including DIGIT_BLANK, turns every segment off.
module seg7_decoder
  import round_controller_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/round_controller.sv
// Two-player fighting-game round controller: health, invulnerability windows,
// KO pause, round/match scoring and the six-digit score display.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int MAX_HEALTH    = 10,
  parameter int BASIC_DMG     = 1,
  parameter int DIR_DMG       = 2,
  parameter int INVULN_FRAMES = 30,
  parameter int KO_FRAMES     = 120,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] p1_hit,
  input  logic [1:0] p2_hit,
  input  logic       restart,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] phase,
  output logic       freeze,
  output logic [1:0] winner,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam logic [6:0]  HEALTH_INIT = 7'(MAX_HEALTH);
  localparam logic [6:0]  BASIC_D     = 7'(BASIC_DMG);
  localparam logic [6:0]  DIR_D       = 7'(DIR_DMG);
  localparam logic [15:0] INV_LOAD    = 16'(INVULN_FRAMES);
  localparam logic [15:0] KO_LAST     = 16'(KO_FRAMES - 1);
  localparam logic [1:0]  WIN_ROUNDS  = 2'(ROUNDS_TO_WIN);

  phase_t      state;
  logic [1:0]  p1_prev, p2_prev;
  logic [15:0] p1_inv, p2_inv, ko_cnt;
  logic        p1_ev, p2_ev;
  logic [6:0]  p1_dmg, p2_dmg, p1_next, p2_next;
  logic [7:0]  p1_digits, p2_digits;

  // A hit only counts on the 00 -> non-zero transition of the detector flag.
  always_comb begin
    p1_ev   = (p1_hit != HIT_NONE) && (p1_prev == HIT_NONE) && (state == PH_FIGHT) && (p1_inv == 16'd0);
    p2_ev   = (p2_hit != HIT_NONE) && (p2_prev == HIT_NONE) && (state == PH_FIGHT) && (p2_inv == 16'd0);
    p1_dmg  = (p1_hit == HIT_BASIC) ? BASIC_D : DIR_D;
    p2_dmg  = (p2_hit == HIT_BASIC) ? BASIC_D : DIR_D;
    p1_next = p1_health;
    p2_next = p2_health;
    if (p1_ev) p1_next = (p1_health > p1_dmg) ? p1_health - p1_dmg : 7'd0;
    if (p2_ev) p2_next = (p2_health > p2_dmg) ? p2_health - p2_dmg : 7'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PH_FIGHT;
      freeze    <= 1'b0;
      winner    <= WIN_NONE;
      p1_health <= HEALTH_INIT;
      p2_health <= HEALTH_INIT;
      p1_rounds <= 2'd0;
      p2_rounds <= 2'd0;
      p1_inv    <= 16'd0;
      p2_inv    <= 16'd0;
      ko_cnt    <= 16'd0;
      p1_prev   <= HIT_NONE;
      p2_prev   <= HIT_NONE;
    end else begin
      p1_prev <= p1_hit;
      p2_prev <= p2_hit;
      case (state)
        PH_FIGHT: begin
          p1_health <= p1_next;
          p2_health <= p2_next;
          if (p1_ev) p1_inv <= INV_LOAD;
          else if (frame_tick && p1_inv != 16'd0) p1_inv <= p1_inv - 16'd1;
          if (p2_ev) p2_inv <= INV_LOAD;
          else if (frame_tick && p2_inv != 16'd0) p2_inv <= p2_inv - 16'd1;
          if (p1_next == 7'd0 || p2_next == 7'd0) begin
            state  <= PH_KO;
            freeze <= 1'b1;
            ko_cnt <= 16'd0;
            // A double KO scores for nobody.
            if (p1_next == 7'd0 && p2_next != 7'd0 && p2_rounds != WIN_ROUNDS)
              p2_rounds <= p2_rounds + 2'd1;
            if (p2_next == 7'd0 && p1_next != 7'd0 && p1_rounds != WIN_ROUNDS)
              p1_rounds <= p1_rounds + 2'd1;
          end
        end
        PH_KO: begin
          if (frame_tick) begin
            if (ko_cnt == KO_LAST) begin
              if (p1_rounds == WIN_ROUNDS || p2_rounds == WIN_ROUNDS) begin
                state  <= PH_OVER;
                winner <= (p1_rounds == WIN_ROUNDS) ? WIN_P1 : WIN_P2;
              end else begin
                state     <= PH_FIGHT;
                freeze    <= 1'b0;
                p1_health <= HEALTH_INIT;
                p2_health <= HEALTH_INIT;
                p1_inv    <= 16'd0;
                p2_inv    <= 16'd0;
              end
            end else begin
              ko_cnt <= ko_cnt + 16'd1;
            end
          end
        end
        PH_OVER: begin
          if (restart) begin
            state     <= PH_FIGHT;
            freeze    <= 1'b0;
            winner    <= WIN_NONE;
            p1_health <= HEALTH_INIT;
            p2_health <= HEALTH_INIT;
            p1_rounds <= 2'd0;
            p2_rounds <= 2'd0;
            p1_inv    <= 16'd0;
            p2_inv    <= 16'd0;
          end
        end
        default: state <= PH_FIGHT;
      endcase
    end
  end

  assign phase     = state;
  assign p1_digits = health_digits(p1_health);
  assign p2_digits = health_digits(p2_health);

  seg7_decoder u_hex5 (.digit(p1_digits[7:4]),     .seg(hex5));
  seg7_decoder u_hex4 (.digit(p1_digits[3:0]),     .seg(hex4));
  seg7_decoder u_hex3 (.digit({2'b00, p1_rounds}), .seg(hex3));
  seg7_decoder u_hex2 (.digit({2'b00, p2_rounds}), .seg(hex2));
  seg7_decoder u_hex1 (.digit(p2_digits[7:4]),     .seg(hex1));
  seg7_decoder u_hex0 (.digit(p2_digits[3:0]),     .seg(hex0));

endmodule
